// File: rtl/cache_tag_array.sv
// N-way set-associative tag store: tag/valid/dirty per way, registered
// hit/victim lookup, round-robin replacement and a sequenced invalidate-all.
module cache_tag_array #(
   parameter int unsigned TAG_W = 23,
   parameter int unsigned SET_W = 6,
   parameter int unsigned WAYS  = 2,
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lk_valid,
   input  logic [SET_W-1:0] lk_set,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             lk_ready,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output logic [WAY_W-1:0] rsp_way,
   output logic             rsp_dirty,
   output logic [TAG_W-1:0] rsp_vtag,
   input  logic             wr_en,
   input  logic [SET_W-1:0] wr_set,
   input  logic [WAY_W-1:0] wr_way,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             wr_valid,
   input  logic             wr_dirty,
   input  logic             inv_start,
   output logic             busy,
   output logic             inv_done
);

   localparam int unsigned SETS = 2 ** SET_W;

   typedef enum logic {
      S_IDLE,
      S_INV
   } state_t;

   state_t                           state;
   logic [SET_W-1:0]                 inv_cnt;
   logic [SETS-1:0][WAYS-1:0]        valid_q;
   logic [SETS-1:0][WAYS-1:0]        dirty_q;
   logic [SETS-1:0][WAY_W-1:0]       ptr_q;
   logic [TAG_W-1:0]                 tag_mem [SETS][WAYS];

   logic             accept;
   logic             wr_ok;
   logic             hit_c;
   logic [WAY_W-1:0] hit_way_c;
   logic             free_c;
   logic [WAY_W-1:0] free_way_c;
   logic [WAY_W-1:0] sel_way_c;
   logic [WAY_W-1:0] nxt_ptr_c;

   // Lookups and writes are frozen during the invalidate walk; inv_start beats a lookup.
   assign lk_ready = !busy;
   assign accept   = lk_valid && !busy && !inv_start;
   assign wr_ok    = wr_en && !busy;

   // Round-robin pointer advances past the way just filled, wrapping at WAYS.
   assign nxt_ptr_c = (32'(wr_way) == WAYS - 1) ? '0 : wr_way + WAY_W'(1);

   // Tag compare and victim choice; descending scan so the lowest index wins.
   always_comb begin
      hit_c      = 1'b0;
      hit_way_c  = '0;
      free_c     = 1'b0;
      free_way_c = '0;
      sel_way_c  = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (valid_q[lk_set][WAY_W'(w)] && (tag_mem[lk_set][WAY_W'(w)] == lk_tag)) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
         if (!valid_q[lk_set][WAY_W'(w)]) begin
            free_c     = 1'b1;
            free_way_c = WAY_W'(w);
         end
      end
      if (hit_c) begin
         sel_way_c = hit_way_c;
      end else if (free_c || (WAYS == 1)) begin
         sel_way_c = free_way_c;
      end else begin
         sel_way_c = ptr_q[lk_set];
      end
   end

   // Tag storage carries no reset; entries are qualified by valid bits.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         tag_mem[wr_set][wr_way] <= wr_tag;
      end
   end

   // State bits, lookup response and invalidate-walk FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         dirty_q   <= '0;
         ptr_q     <= '0;
         state     <= S_IDLE;
         inv_cnt   <= '0;
         busy      <= 1'b0;
         inv_done  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_way   <= '0;
         rsp_dirty <= 1'b0;
         rsp_vtag  <= '0;
      end else begin
         inv_done  <= 1'b0;
         rsp_valid <= accept;
         if (accept) begin
            rsp_hit   <= hit_c;
            rsp_way   <= sel_way_c;
            rsp_dirty <= dirty_q[lk_set][sel_way_c];
            rsp_vtag  <= tag_mem[lk_set][sel_way_c];
         end
         if (wr_ok) begin
            valid_q[wr_set][wr_way] <= wr_valid;
            dirty_q[wr_set][wr_way] <= wr_dirty;
            if (wr_valid) begin
               ptr_q[wr_set] <= nxt_ptr_c;
            end
         end
         case (state)
            S_IDLE: begin
               if (inv_start) begin
                  state   <= S_INV;
                  inv_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            S_INV: begin
               valid_q[inv_cnt] <= '0;
               dirty_q[inv_cnt] <= '0;
               inv_cnt          <= inv_cnt + SET_W'(1);
               if (inv_cnt == SET_W'(SETS - 1)) begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  inv_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench for cache_tag_array with a queue-based response scoreboard.
module tb_cache_tag_array;

   logic        clk = 1'b0;
   logic        rst;
   logic        lk_valid;
   logic [5:0]  lk_set;
   logic [22:0] lk_tag;
   logic        lk_ready;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [0:0]  rsp_way;
   logic        rsp_dirty;
   logic [22:0] rsp_vtag;
   logic        wr_en;
   logic [5:0]  wr_set;
   logic [0:0]  wr_way;
   logic [22:0] wr_tag;
   logic        wr_valid;
   logic        wr_dirty;
   logic        inv_start;
   logic        busy;
   logic        inv_done;

   typedef struct {
      logic        hit;
      logic [0:0]  way;
      logic        dirty;
      logic [22:0] vtag;
      bit          use_vtag;
   } exp_t;

   exp_t sbq[$];
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   cache_tag_array #(.TAG_W(23), .SET_W(6), .WAYS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .lk_valid  (lk_valid),
      .lk_set    (lk_set),
      .lk_tag    (lk_tag),
      .lk_ready  (lk_ready),
      .rsp_valid (rsp_valid),
      .rsp_hit   (rsp_hit),
      .rsp_way   (rsp_way),
      .rsp_dirty (rsp_dirty),
      .rsp_vtag  (rsp_vtag),
      .wr_en     (wr_en),
      .wr_set    (wr_set),
      .wr_way    (wr_way),
      .wr_tag    (wr_tag),
      .wr_valid  (wr_valid),
      .wr_dirty  (wr_dirty),
      .inv_start (inv_start),
      .busy      (busy),
      .inv_done  (inv_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [5:0] s, input logic [22:0] t, input logic h,
                         input logic [0:0] w, input logic d, input logic [22:0] vt,
                         input bit uv);
      exp_t e;
      e.hit = h; e.way = w; e.dirty = d; e.vtag = vt; e.use_vtag = uv;
      lk_valid = 1'b1;
      lk_set   = s;
      lk_tag   = t;
      sbq.push_back(e);
      tick();
      lk_valid = 1'b0;
   endtask

   task automatic set_wr(input logic [5:0] s, input logic [0:0] w, input logic [22:0] t,
                         input logic v, input logic d);
      wr_set   = s;
      wr_way   = w;
      wr_tag   = t;
      wr_valid = v;
      wr_dirty = d;
   endtask

   task automatic write(input logic [5:0] s, input logic [0:0] w, input logic [22:0] t,
                        input logic v, input logic d);
      set_wr(s, w, t, v, d);
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   // Monitor: every presented response is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            tot_cnt++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 with no lookup pending");
         end else begin
            e = sbq.pop_front();
            chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
            chk("rsp_way", 32'(rsp_way), 32'(e.way));
            chk("rsp_dirty", 32'(rsp_dirty), 32'(e.dirty));
            if (e.use_vtag) chk("rsp_vtag", 32'(rsp_vtag), 32'(e.vtag));
         end
      end
   end

   initial begin
      int bc;
      int dc;
      int rdy_bad;
      rst = 1'b1; lk_valid = 1'b0; lk_set = '0; lk_tag = '0;
      wr_en = 1'b0; inv_start = 1'b0;
      set_wr(6'd0, 1'b0, 23'h0, 1'b0, 1'b0);
      repeat (3) tick();
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
      chk("rst_rsp_way", 32'(rsp_way), 32'd0);
      chk("rst_rsp_dirty", 32'(rsp_dirty), 32'd0);
      chk("rst_rsp_vtag", 32'(rsp_vtag), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_inv_done", 32'(inv_done), 32'd0);
      chk("rst_lk_ready", 32'(lk_ready), 32'd1);
      rst = 1'b0;

      // Cold miss, then hit and invalid-way victim.
      lookup(6'd5, 23'h1234, 1'b0, 1'b0, 1'b0, 23'h0, 1'b0);
      write(6'd5, 1'b0, 23'h1234, 1'b1, 1'b1);
      lookup(6'd5, 23'h1234, 1'b1, 1'b0, 1'b1, 23'h1234, 1'b1);
      lookup(6'd5, 23'h999, 1'b0, 1'b1, 1'b0, 23'h0, 1'b0);

      // Round-robin replacement on a full set.
      write(6'd3, 1'b0, 23'hA, 1'b1, 1'b0);
      write(6'd3, 1'b1, 23'hB, 1'b1, 1'b1);
      lookup(6'd3, 23'hC, 1'b0, 1'b0, 1'b0, 23'hA, 1'b1);
      write(6'd3, 1'b0, 23'hD, 1'b1, 1'b0);
      lookup(6'd3, 23'hE, 1'b0, 1'b1, 1'b1, 23'hB, 1'b1);
      lookup(6'd3, 23'hB, 1'b1, 1'b1, 1'b1, 23'hB, 1'b1);

      // Same-cycle write and lookup: read-before-write.
      set_wr(6'd7, 1'b0, 23'hAB, 1'b1, 1'b0);
      wr_en = 1'b1;
      lookup(6'd7, 23'hAB, 1'b0, 1'b0, 1'b0, 23'h0, 1'b0);
      wr_en = 1'b0;
      lookup(6'd7, 23'hAB, 1'b1, 1'b0, 1'b0, 23'hAB, 1'b1);

      // Full invalidate walk; lookup blocked in start cycle, write performed.
      write(6'd0, 1'b1, 23'h55, 1'b1, 1'b1);
      write(6'd63, 1'b0, 23'h66, 1'b1, 1'b1);
      inv_start = 1'b1;
      lk_valid = 1'b1; lk_set = 6'd0; lk_tag = 23'h55;
      set_wr(6'd10, 1'b0, 23'h77, 1'b1, 1'b1);
      wr_en = 1'b1;
      tick();
      inv_start = 1'b0;
      wr_en = 1'b0;
      bc = 0; dc = 0; rdy_bad = 0;
      for (int n = 1; n <= 70; n++) begin
         @(negedge clk);
         if (busy) bc++;
         if (inv_done) dc++;
         if (lk_ready !== !busy) rdy_bad++;
         if (n == 40) begin
            set_wr(6'd20, 1'b0, 23'h88, 1'b1, 1'b1);
            wr_en = 1'b1;
         end
         if (n == 41) wr_en = 1'b0;
         if (n == 60) lk_valid = 1'b0;
      end
      chk("walk_busy_cycles", 32'(bc), 32'd64);
      chk("walk_done_pulses", 32'(dc), 32'd1);
      chk("walk_ready_is_not_busy", 32'(rdy_bad), 32'd0);
      lookup(6'd0, 23'h55, 1'b0, 1'b0, 1'b0, 23'h0, 1'b0);
      lookup(6'd63, 23'h66, 1'b0, 1'b0, 1'b0, 23'h66, 1'b1);
      lookup(6'd20, 23'h88, 1'b0, 1'b0, 1'b0, 23'h0, 1'b0);
      lookup(6'd10, 23'h1, 1'b0, 1'b0, 1'b0, 23'h77, 1'b1);

      // Reset during a walk aborts it without inv_done.
      write(6'd50, 1'b0, 23'h321, 1'b1, 1'b1);
      write(6'd50, 1'b1, 23'h322, 1'b1, 1'b1);
      inv_start = 1'b1;
      tick();
      inv_start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 20) rst = 1'b1;
      end
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_inv_done", 32'(inv_done), 32'd0);
      chk("abort_lk_ready", 32'(lk_ready), 32'd1);
      chk("abort_rsp_vtag", 32'(rsp_vtag), 32'd0);
      rst = 1'b0;
      bc = 0; dc = 0;
      for (int n = 1; n <= 70; n++) begin
         @(negedge clk);
         if (busy) bc++;
         if (inv_done) dc++;
      end
      chk("abort_no_busy", 32'(bc), 32'd0);
      chk("abort_no_done", 32'(dc), 32'd0);
      lookup(6'd50, 23'h321, 1'b0, 1'b0, 1'b0, 23'h321, 1'b1);
      lookup(6'd50, 23'h322, 1'b0, 1'b0, 1'b0, 23'h321, 1'b1);

      repeat (3) tick();
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/cache_tag_array.md
Name: cache_tag_array

Overview:
- Parametrised N-way set-associative tag store for the L1 I/D caches; successor to the single-way tag RAM.
- Holds tag, valid and dirty per way per set. Returns a registered hit/miss result with hit way and replacement victim.
- Provides a sequenced invalidate-all for fence.i and flush.
- Sits between the cache control FSM and the data arrays.

Parameters:
TAG_W, 23, tag width in bits
SET_W, 6, set index width; SETS = 2**SET_W
WAYS, 2, associativity; legal values 1, 2, 4
WAY_W, derived, max(1, log2(WAYS))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lk_valid  in  1  lookup request
lk_set  in  SET_W  lookup set index
lk_tag  in  TAG_W  lookup tag
lk_ready  out  1  lookup accepted this cycle (= !busy)
rsp_valid  out  1  result valid, one cycle after accepted lookup
rsp_hit  out  1  tag match on a valid way
rsp_way  out  WAY_W  hit way, else victim way
rsp_dirty  out  1  dirty bit of rsp_way
rsp_vtag  out  TAG_W  stored tag of rsp_way (writeback address)
wr_en  in  1  update one entry
wr_set  in  SET_W  update set
wr_way  in  WAY_W  update way
wr_tag  in  TAG_W  tag to write
wr_valid  in  1  valid bit to write
wr_dirty  in  1  dirty bit to write
inv_start  in  1  begin invalidate-all
busy  out  1  invalidate walk in progress
inv_done  out  1  one-cycle pulse at walk end

Behaviour:
- Reset (rst=1 at posedge): all valid/dirty bits = 0, all round-robin pointers = 0, FSM = IDLE. Outputs: rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_dirty=0, rsp_vtag=0, busy=0, inv_done=0, lk_ready=1. Tag storage is not reset. Reset mid-walk aborts the walk with no inv_done.
- Lookup: accepted when lk_valid && lk_ready. Result registered; rsp_valid=1 exactly the next cycle, else 0. rsp_* hold their last value when rsp_valid=0.
- Hit: some way w has valid[w] && tag[w]==lk_tag. If several ways match (illegal), the lowest index wins. rsp_way=w; rsp_dirty and rsp_vtag come from way w.
- Miss victim: the lowest-index invalid way. If all ways are valid, the set's round-robin pointer. rsp_dirty and rsp_vtag are from the victim.
- Write: wr_en at posedge writes tag, valid and dirty to (wr_set, wr_way). If wr_valid=1, the set pointer becomes (wr_way+1) mod WAYS, wrapping.
- WAYS=1: victim is always way 0; the pointer is unused.
- Same-cycle write and lookup to the same set: the lookup sees pre-write contents (read-before-write). No bypass.
- FSM states:
  - IDLE: inv_start -> INV, counter=0, busy=1.
  - INV: clears valid and dirty of all ways in set=counter each cycle, counter++. After set SETS-1 -> IDLE, busy=0, inv_done=1 for one cycle.
  - Walk length is exactly SETS cycles.
- While busy: lk_ready=0, lookups ignored, wr_en ignored, inv_start ignored.
- inv_start in IDLE takes priority over a same-cycle lookup: the lookup is not accepted.
- A same-cycle wr_en in the inv_start cycle is still performed.

Test Plan:
- Reset then lookup set 5, tag 0x1234 -> next cycle rsp_valid=1, rsp_hit=0, rsp_way=0, rsp_dirty=0.
- Write set 5 way 0 tag 0x1234 valid=1 dirty=1, then lookup 0x1234 -> rsp_hit=1, rsp_way=0, rsp_dirty=1, rsp_vtag=0x1234. Lookup 0x999 -> rsp_hit=0, rsp_way=1 (invalid way).
- WAYS=2: fill set 3 way 0 then way 1, lookup miss -> rsp_way=0 (pointer wrapped). Fill way 0, miss -> rsp_way=1, rsp_vtag = way-1 tag.
- Same cycle: write set 7 way 0 tag 0xAB valid, plus lookup set 7 tag 0xAB -> rsp_hit=0. Repeat lookup -> rsp_hit=1.
- Fill sets 0 and 63, pulse inv_start -> busy high for 64 cycles, lk_ready=0, inv_done pulses once. Following lookups all miss with rsp_dirty=0.
- Assert rst at cycle 20 of a walk -> busy=0 next cycle, no inv_done, all entries invalid.
